truth_table_checker: RTL

//  Self-sequencing exhaustive checker for an N-input, 1-output combinational DUT.
//  - On start: sweeps every input vector 0..2**N_IN-1 into the DUT.
//  - Compares each DUT response against a parameterised truth table.
//  - Counts mismatches, records the first failing vector and reports pass/fail.
//  - Sits beside the DUT on the lab bench and replaces hand-written vector loops.

---
 rtl/truth_table_checker.sv | 94 +++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: self-sequencing exhaustive checker for an N_IN-input, 1-output combinational DUT
// Sweeps x = 0 .. 2**N_IN-1. Each vector is held for SETTLE cycles and then sampled in one SAMPLE cycle.
// Each DUT response is compared against TRUTH_TABLE[x]. Mismatches are counted and the first failing vector is recorded.
// Ports: clk, rst (async, active-high), start, dut_z -> x, busy, done, pass, err, err_cnt, first_err_vec, first_err_vld
// Optional build macro CHECKER_STOP_ON_ERR_EN: the first mismatch ends the sweep with x held at the failing vector.
module truth_table_checker #(
    parameter int N_IN = 3,
    parameter logic [2**N_IN-1:0] TRUTH_TABLE = 8'b01100001,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_z,
    output logic [N_IN-1:0] x,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            err,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_vld
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] X_LAST = '1;

    logic [1:0]    state;
    logic [CW-1:0] settle_cnt;
    logic          last;

    assign err = dut_z != TRUTH_TABLE[x];

`ifdef CHECKER_STOP_ON_ERR_EN
    assign last = err || x == X_LAST;
`else
    assign last = x == X_LAST;
`endif

    // FIN's outputs land on the edge that leaves FIN, so done/pass appear
    // together in the first IDLE cycle after the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
            settle_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err_cnt       <= '0;
                    first_err_vld <= 1'b0;
                    pass          <= 1'b0;
                    x             <= '0;
                    busy          <= 1'b1;
                    settle_cnt    <= '0;
                    state         <= HOLD;
                end
                HOLD: begin
                    settle_cnt <= settle_cnt == SETTLE_LAST ? '0 : settle_cnt + 1'b1;
                    state      <= settle_cnt == SETTLE_LAST ? SAMPLE : HOLD;
                end
                SAMPLE: begin
                    if (err) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_err_vld) begin
                            first_err_vec <= x;
                            first_err_vld <= 1'b1;
                        end
                    end
                    x     <= last ? x : x + 1'b1;
                    state <= last ? FIN : HOLD;
                end
                default: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= err_cnt == '0;
                    x     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
